fetch_pc_ctrl: RTL and testbench

Fetch-stage sequencer between the instruction address generator and the I-cache. It owns the fetch PC, issues in-order requests to the I-cache under a credit limit, and redirects on exception or branch-mispredict. It discards responses belonging to killed requests and buffers surviving responses toward the decoder with a stall handshake. The block drives the `inst_e_` / `inst_pc` / `inst` signals consumed by `FetchDecIf`.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_resp_queue.sv | 62 ++++++
 rtl/fetch_pc_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

    localparam int ADDR_W     = 32;
    localparam int INST_W     = 32;
    localparam int INST_BYTES = INST_W / 8;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } FetchState_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } FetchEntry_t;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/fetch_resp_queue.sv
// Small synchronous FIFO with occupancy count and single-cycle flush.
module fetch_resp_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full queue may still accept a push when it is popped in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                mem_q[gi] <= '0;
            end else if (do_push && !flush_i && (wr_ptr_q == PW'(gi))) begin
                mem_q[gi] <= push_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: credit-limited in-order I-cache requests, redirect with
// kill of in-flight responses, and a response queue toward the decoder.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int              ADDR      = ADDR_W,
    parameter int              INST      = INST_W,
    parameter logic [ADDR-1:0] RESET_VEC = '0,
    parameter int              MAX_OUT   = 2
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            exc_valid,
    input  logic [ADDR-1:0] exc_target,
    input  logic            br_valid,
    input  logic [ADDR-1:0] br_target,
    input  logic            halt,
    output logic            ic_req_valid,
    output logic [ADDR-1:0] ic_req_pc,
    input  logic            ic_req_ready,
    input  logic            ic_resp_valid,
    input  logic [INST-1:0] ic_resp_inst,
    input  logic            dec_stall,
    output logic            inst_e_,
    output logic [ADDR-1:0] inst_pc,
    output logic [INST-1:0] inst
);
    localparam int              CW         = cnt_width(MAX_OUT);
    localparam int              STEP       = INST / 8;
    localparam logic [ADDR-1:0] ALIGN_MASK = ~(ADDR'(STEP - 1));

    FetchState_t     state_q;
    logic [ADDR-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   q_cnt;
    logic [CW-1:0]   pcf_cnt;
    logic [ADDR-1:0] resp_pc;
    logic [ADDR-1:0] redir_tgt;
    logic            redirect;
    logic            credit_ok;
    logic            accept;
    logic            resp_hit;
    logic            resp_keep;
    logic            dec_pop;

    assign redirect  = (exc_valid || br_valid) && (state_q != BOOT);
    assign redir_tgt = (exc_valid ? exc_target : br_target) & ALIGN_MASK;

    // Credit covers both requests still in the I-cache and responses parked here.
    assign credit_ok    = ({1'b0, out_cnt_q} + {1'b0, q_cnt}) < (CW+1)'(MAX_OUT);
    assign ic_req_valid = (state_q == FETCH) && !redirect && credit_ok;
    assign ic_req_pc    = pc_q;
    assign accept       = ic_req_valid && ic_req_ready;

    assign resp_hit  = ic_resp_valid && (out_cnt_q != '0);
    assign resp_keep = resp_hit && (drop_cnt_q == '0) && !redirect;
    assign inst_e_   = redirect || (q_cnt == '0);
    assign dec_pop   = !dec_stall && !inst_e_;

    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q + CW'(accept) - CW'(resp_hit);
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            pc_d       = redir_tgt;
            drop_cnt_d = out_cnt_q - CW'(resp_hit);
        end else begin
            if (accept) pc_d = pc_q + ADDR'(STEP);
            if (resp_hit && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            case (state_q)
                BOOT:    state_q <= FETCH;
                FETCH:   if (halt && !redirect) state_q <= HALT;
                HALT:    if (redirect || !halt) state_q <= FETCH;
                default: state_q <= BOOT;
            endcase
        end
    end

    // The PC FIFO pairs each in-order response with the address it was fetched from.
    fetch_resp_queue #(.DEPTH(MAX_OUT), .WIDTH(ADDR)) u_pc_fifo (
        .clk         (clk),
        .reset_      (reset_),
        .flush_i     (1'b0),
        .push_i      (accept),
        .push_data_i (pc_q),
        .pop_i       (resp_hit),
        .head_o      (resp_pc),
        .count_o     (pcf_cnt)
    );

    fetch_resp_queue #(.DEPTH(MAX_OUT), .WIDTH(ADDR + INST)) u_resp_q (
        .clk         (clk),
        .reset_      (reset_),
        .flush_i     (redirect),
        .push_i      (resp_keep),
        .push_data_i ({resp_pc, ic_resp_inst}),
        .pop_i       (dec_pop),
        .head_o      ({inst_pc, inst}),
        .count_o     (q_cnt)
    );

    resp_protocol_a: assert property (@(posedge clk) disable iff (!reset_)
        ic_resp_valid |-> (out_cnt_q != '0));
    pc_track_a: assert property (@(posedge clk) disable iff (!reset_)
        pcf_cnt == out_cnt_q);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl with a variable-latency I-cache model.
module tb_fetch_pc_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_;
    logic        exc_valid, br_valid, halt;
    logic [31:0] exc_target, br_target;
    logic        ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [31:0] ic_req_pc, ic_resp_inst;
    logic        dec_stall, inst_e_;
    logic [31:0] inst_pc, inst;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.ADDR(32), .INST(32), .RESET_VEC(32'h0), .MAX_OUT(2)) dut (
        .clk          (clk),
        .reset_       (reset_),
        .exc_valid    (exc_valid),
        .exc_target   (exc_target),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .halt         (halt),
        .ic_req_valid (ic_req_valid),
        .ic_req_pc    (ic_req_pc),
        .ic_req_ready (ic_req_ready),
        .ic_resp_valid(ic_resp_valid),
        .ic_resp_inst (ic_resp_inst),
        .dec_stall    (dec_stall),
        .inst_e_      (inst_e_),
        .inst_pc      (inst_pc),
        .inst         (inst)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          due;
        bit          killed;
    } pend_t;

    typedef struct {
        int          lat;
        bit          exc;
        logic [31:0] etgt;
        bit          br;
        logic [31:0] btgt;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } redir_vec_t;

    pend_t       pend_q[$];
    FetchEntry_t sb_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_pc;
    int          cyc, lat, n_tests, n_fail;
    redir_vec_t  vecs[4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: inputs are already set at the negedge on entry.
    task automatic tick();
        bit          redir, exp_e, acc;
        FetchEntry_t e;
        pend_t       p;
        #1;
        redir = exc_valid || br_valid;
        exp_e = redir || (sb_q.size() == 0);
        check("inst_e_", 32'(inst_e_), 32'(exp_e));
        if (!exp_e && !dec_stall) begin
            e = sb_q.pop_front();
            check("inst_pc", inst_pc, e.pc);
            check("inst", inst, e.inst);
            pop_log.push_back(inst_pc);
            $display("[TB] cyc=%0d decode pc=0x%08h inst=0x%08h", cyc, inst_pc, inst);
        end
        if (redir) begin
            check("req_valid_in_redirect", 32'(ic_req_valid), 32'd0);
            sb_q.delete();
            foreach (pend_q[i]) pend_q[i].killed = 1'b1;
            exp_pc = (exc_valid ? exc_target : br_target) & ~32'd3;
        end
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            ic_resp_valid = 1'b1;
            ic_resp_inst  = p.inst;
            if (!p.killed) begin
                e.pc   = p.pc;
                e.inst = mem_word(p.pc);
                sb_q.push_back(e);
            end
        end
        acc = ic_req_valid && ic_req_ready;
        if (acc) begin
            check("ic_req_pc", ic_req_pc, exp_pc);
            p.pc     = exp_pc;
            p.inst   = mem_word(ic_req_pc);
            p.due    = cyc + lat;
            p.killed = 1'b0;
            pend_q.push_back(p);
            acc_log.push_back(ic_req_pc);
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        ic_resp_valid = 1'b0;
    endtask

    task automatic drain();
        ic_req_ready = 1'b0;
        dec_stall    = 1'b0;
        halt         = 1'b0;
        exc_valid    = 1'b0;
        br_valid     = 1'b0;
        repeat (10) tick();
        check("drained_inst_e_", 32'(inst_e_), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; lat = 1;
        reset_ = 1'b0; exc_valid = 1'b0; br_valid = 1'b0; halt = 1'b0;
        exc_target = '0; br_target = '0; ic_req_ready = 1'b0;
        ic_resp_valid = 1'b0; ic_resp_inst = '0; dec_stall = 1'b0;
        exp_pc = 32'h0;

        vecs[0] = '{3, 1'b0, 32'h0,  1'b1, 32'h1003,      32'h1000,      32'h1004};
        vecs[1] = '{2, 1'b1, 32'h80, 1'b1, 32'h200,       32'h80,        32'h84};
        vecs[2] = '{1, 1'b1, 32'h7F, 1'b0, 32'h0,         32'h7C,        32'h80};
        vecs[3] = '{3, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};

        repeat (3) @(negedge clk);
        check("rst_req_valid", 32'(ic_req_valid), 32'd0);
        check("rst_req_pc", ic_req_pc, 32'h0);
        check("rst_inst_e_", 32'(inst_e_), 32'd1);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst", inst, 32'h0);

        // Reset release: BOOT, then sequential fetch with 1-cycle latency.
        ic_req_ready = 1'b1;
        reset_ = 1'b1;
        #1;
        check("boot_req_valid", 32'(ic_req_valid), 32'd0);
        repeat (3) tick();
        #1;
        check("first_inst_e_", 32'(inst_e_), 32'd0);
        check("first_inst_pc", inst_pc, 32'h0);
        repeat (12) tick();
        check("seq_req0", (acc_log.size() > 2) ? acc_log[0] : 32'hDEAD_BEEF, 32'h0);
        check("seq_req1", (acc_log.size() > 2) ? acc_log[1] : 32'hDEAD_BEEF, 32'h4);
        check("seq_req2", (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF, 32'h8);
        drain();

        // Decoder stall: credit limit caps issue at MAX_OUT.
        lat = 1; ic_req_ready = 1'b1; dec_stall = 1'b1;
        acc_log.delete(); pop_log.delete();
        repeat (8) tick();
        check("stall_accepts", 32'(acc_log.size()), 32'd2);
        check("stall_req_valid", 32'(ic_req_valid), 32'd0);
        check("stall_inst_e_", 32'(inst_e_), 32'd0);
        dec_stall = 1'b0;
        repeat (8) tick();
        check("stall_drain_order", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF,
              (acc_log.size() > 0) ? acc_log[0] : 32'hBAD0_BAD0);
        check("stall_resume", 32'(acc_log.size() > 2), 32'd1);
        drain();

        // Redirect vectors: kill in-flight work, align target, priority, wrap.
        for (int v = 0; v < 4; v++) begin
            lat = vecs[v].lat; ic_req_ready = 1'b1; dec_stall = 1'b0;
            repeat (2) tick();
            exc_valid = vecs[v].exc; exc_target = vecs[v].etgt;
            br_valid  = vecs[v].br;  br_target  = vecs[v].btgt;
            acc_log.delete(); pop_log.delete();
            tick();
            exc_valid = 1'b0; br_valid = 1'b0;
            repeat (12) tick();
            check($sformatf("redir%0d_req0", v), (acc_log.size() > 1) ? acc_log[0] : 32'hDEAD_BEEF, vecs[v].exp0);
            check($sformatf("redir%0d_req1", v), (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF, vecs[v].exp1);
            check($sformatf("redir%0d_first_dec", v), (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, vecs[v].exp0);
            drain();
        end

        // Halt with one request outstanding, then a one-shot redirect during HALT.
        lat = 3; ic_req_ready = 1'b1; halt = 1'b1;
        acc_log.delete(); pop_log.delete();
        repeat (8) tick();
        check("halt_accepts", 32'(acc_log.size()), 32'd1);
        check("halt_delivered", 32'(pop_log.size()), 32'd1);
        check("halt_req_valid", 32'(ic_req_valid), 32'd0);
        br_valid = 1'b1; br_target = 32'h300;
        tick();
        br_valid = 1'b0;
        acc_log.delete();
        repeat (8) tick();
        check("halt_br_accepts", 32'(acc_log.size()), 32'd1);
        check("halt_br_pc", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h300);
        check("halt_br_rehalt", 32'(ic_req_valid), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
